// File: rtl/wormhole_router.sv
// rtl/wormhole_router.sv - 5-port XY wormhole router: per-input FIFOs, round-robin output locks, on/off flow control.
// Define ROUTER_STATS_EN to add saturating per-output forwarded-flit counters on flit_count_o.

module router_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int OFF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              drop,
  output logic              ready
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] OFF_C   = (PTR_W+1)'(OFF_MARGIN);
  localparam logic [PTR_W:0] ON_C    = (PTR_W+1)'(2 * OFF_MARGIN);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count, count_next, free_next;
  logic              full, wr_ok, rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign rd_ok   = rd_en && !empty;
  // A full FIFO still takes the write when its head leaves in the same cycle.
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign drop    = wr_en && !wr_ok;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)
      count_next = count + 1'b1;
    else if (!wr_ok && rd_ok)
      count_next = count - 1'b1;
  end

  assign free_next = DEPTH_C - count_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (free_next <= OFF_C)
        ready <= 1'b0;
      else if (free_next >= ON_C)
        ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end
endmodule

module wormhole_router #(
  parameter int DATA_W      = 32,
  parameter int BUFFER_SIZE = 8,
  parameter int OFF_MARGIN  = 2,
  parameter int ADDR_X_W    = 3,
  parameter int ADDR_Y_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_X_W-1:0]    x_current,
  input  logic [ADDR_Y_W-1:0]    y_current,
  input  logic [4:0][DATA_W-1:0] data_in,
  input  logic [4:0]             is_valid_in,
  output logic [4:0]             is_on_off_out,
  output logic [4:0][DATA_W-1:0] data_out,
  output logic [4:0]             is_valid_out,
  input  logic [4:0]             is_on_off_in,
`ifdef ROUTER_STATS_EN
  output logic [4:0][15:0]       flit_count_o,
`endif
  output logic [4:0]             error_o
);
  localparam int NP = 5;
  localparam logic [2:0] P_LOCAL = 3'd0, P_NORTH = 3'd1, P_SOUTH = 3'd2, P_WEST = 3'd3, P_EAST = 3'd4;
  localparam logic [1:0] T_HEAD = 2'b00, T_TAIL = 2'b10, T_HT = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, ACTIVE} in_state_t;

  in_state_t                 state [NP];
  in_state_t                 state_next [NP];
  logic [NP-1:0][DATA_W-1:0] head_flit;
  logic [NP-1:0][2:0]        route_calc, route_q, route_req;
  logic [NP-1:0][2:0]        owner_q, ptr_q, winner, fwd_src;
  logic [NP-1:0]             fifo_empty, fifo_drop, is_head, last_flit;
  logic [NP-1:0]             req, bad, granted, fwd_in, pop;
  logic [NP-1:0]             lock_q, grant_v, fwd_v;

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NP) s = s - NP;
    return 3'(s);
  endfunction

  genvar g;
  generate
    for (g = 0; g < NP; g++) begin : g_in
      logic [1:0]          ftype;
      logic [ADDR_X_W-1:0] dx;
      logic [ADDR_Y_W-1:0] dy;

      router_fifo #(.DATA_W(DATA_W), .DEPTH(BUFFER_SIZE), .OFF_MARGIN(OFF_MARGIN)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (is_valid_in[g]),
        .wr_data (data_in[g]),
        .rd_en   (pop[g]),
        .rd_data (head_flit[g]),
        .empty   (fifo_empty[g]),
        .drop    (fifo_drop[g]),
        .ready   (is_on_off_out[g])
      );

      assign ftype        = head_flit[g][DATA_W-1 -: 2];
      assign dx           = head_flit[g][ADDR_X_W-1:0];
      assign dy           = head_flit[g][ADDR_X_W +: ADDR_Y_W];
      assign is_head[g]   = (ftype == T_HEAD) || (ftype == T_HT);
      assign last_flit[g] = (ftype == T_TAIL) || (ftype == T_HT);
      assign route_calc[g] = (dx > x_current) ? P_EAST  :
                             (dx < x_current) ? P_WEST  :
                             (dy > y_current) ? P_NORTH :
                             (dy < y_current) ? P_SOUTH : P_LOCAL;
    end
  endgenerate

  // An IDLE input requests straight from its FIFO head so a fresh head can win in its first cycle.
  always_comb begin
    req       = '0;
    bad       = '0;
    route_req = route_q;
    for (int i = 0; i < NP; i++) begin
      if (state[i] == IDLE && !fifo_empty[i]) begin
        if (is_head[i]) begin
          req[i]       = 1'b1;
          route_req[i] = route_calc[i];
        end else begin
          bad[i] = 1'b1;
        end
      end else if (state[i] == WAIT_GRANT) begin
        req[i] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_v = '0;
    winner  = '0;
    fwd_v   = '0;
    fwd_src = owner_q;
    for (int o = 0; o < NP; o++) begin
      if (lock_q[o]) begin
        fwd_v[o] = is_on_off_in[o] && !fifo_empty[owner_q[o]];
      end else if (is_on_off_in[o]) begin
        for (int k = 0; k < NP; k++) begin
          if (!grant_v[o] && req[rr_idx(ptr_q[o], k)] && route_req[rr_idx(ptr_q[o], k)] == 3'(o)) begin
            grant_v[o] = 1'b1;
            winner[o]  = rr_idx(ptr_q[o], k);
          end
        end
        fwd_v[o]   = grant_v[o];
        fwd_src[o] = winner[o];
      end
    end
  end

  always_comb begin
    fwd_in  = '0;
    granted = '0;
    for (int o = 0; o < NP; o++) begin
      if (fwd_v[o])   fwd_in[fwd_src[o]]  = 1'b1;
      if (grant_v[o]) granted[winner[o]] = 1'b1;
    end
    pop = fwd_in | bad;
  end

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      state_next[i] = state[i];
      case (state[i])
        IDLE, WAIT_GRANT: begin
          if (granted[i]) begin
            if (last_flit[i]) state_next[i] = IDLE;
            else              state_next[i] = ACTIVE;
          end else if (req[i]) begin
            state_next[i] = WAIT_GRANT;
          end
        end
        ACTIVE:  if (fwd_in[i] && last_flit[i]) state_next[i] = IDLE;
        default: state_next[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) state[i] <= IDLE;
      route_q      <= '0;
      lock_q       <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      data_out     <= '0;
      is_valid_out <= '0;
      error_o      <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        state[i] <= state_next[i];
        if (state[i] == IDLE && req[i]) route_q[i] <= route_calc[i];
      end
      for (int o = 0; o < NP; o++) begin
        // A head-tail grant never takes the lock, so it is granted and released at one edge.
        if (grant_v[o]) begin
          ptr_q[o]   <= rr_idx(winner[o], 1);
          owner_q[o] <= winner[o];
          lock_q[o]  <= !last_flit[winner[o]];
        end else if (lock_q[o] && fwd_v[o] && last_flit[owner_q[o]]) begin
          lock_q[o] <= 1'b0;
        end
        if (fwd_v[o]) data_out[o] <= head_flit[fwd_src[o]];
      end
      is_valid_out <= fwd_v;
      error_o      <= error_o | fifo_drop | bad;
    end
  end

`ifdef ROUTER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_count_o <= '0;
    end else begin
      for (int o = 0; o < NP; o++)
        if (fwd_v[o] && flit_count_o[o] != 16'hFFFF)
          flit_count_o[o] <= flit_count_o[o] + 16'd1;
    end
  end
`endif
endmodule
